// File: rtl/lab_sub_pkg.sv
// lab_sub_pkg: shared state encoding and sizing helpers for the iterative borrow subtractor.
package lab_sub_pkg;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   function automatic int nslice(input int width, input int slice);
      return (slice < 1) ? 1 : width / slice;
   endfunction
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/lab_bla_slice_sub.sv
// lab_bla_slice_sub: combinational SLICE-bit borrow-lookahead subtractor slice.
module lab_bla_slice_sub #(
   parameter int SLICE = 4
) (
   output logic [SLICE-1:0] d,
   output logic             bout,
   input  logic [SLICE-1:0] x,
   input  logic [SLICE-1:0] y,
   input  logic             bin
);
   logic [SLICE-1:0] g, p;
   logic [SLICE:0]   b;
   logic             acc, t;
   assign g = ~x & y;
   assign p = ~(x ^ y);
   // each borrow is a flat sum of generate terms gated by downstream propagates
   always_comb begin
      b    = '0;
      b[0] = bin;
      acc  = 1'b0;
      t    = 1'b0;
      for (int i = 0; i < SLICE; i++) begin
         acc = bin;
         for (int j = 0; j <= i; j++) acc = acc & p[j];
         for (int j = 0; j <= i; j++) begin
            t = g[j];
            for (int k = j + 1; k <= i; k++) t = t & p[k];
            acc = acc | t;
         end
         b[i+1] = acc;
      end
   end
   assign d    = ~p ^ b[SLICE-1:0];
   assign bout = b[SLICE];
endmodule

// File: rtl/lab_iterative_borrow_sub.sv
// lab_iterative_borrow_sub: multi-cycle x - y - bin, one borrow-lookahead slice per clock,
// LSB first, with valid/ready on both sides plus zero and signed-overflow flags.
module lab_iterative_borrow_sub
   import lab_sub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] d,
   output logic             bout,
   output logic             zero,
   output logic             ovf
);
   localparam int NSLICE = nslice(WIDTH, SLICE);
   localparam int CW     = cnt_w(NSLICE);

   if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
      $error("WIDTH must be a positive multiple of SLICE");
   end

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             brw_q, brw_d;
   logic [WIDTH-1:0] xl_q, xl_d, yl_q, yl_d, diff_q, diff_d;
   logic             bout_q, bout_d, zero_q, zero_d, ovf_q, ovf_d;
   logic [SLICE-1:0] s_x, s_y, s_d;
   logic             s_bout, accept, run, last;

   assign accept = (state_q == IDLE) && in_valid;
   assign run    = (state_q == RUN);
   assign last   = (cnt_q == CW'(NSLICE - 1));
   assign s_x    = xl_q[cnt_q*SLICE +: SLICE];
   assign s_y    = yl_q[cnt_q*SLICE +: SLICE];

   lab_bla_slice_sub #(.SLICE(SLICE)) u_slice (
      .d(s_d), .bout(s_bout), .x(s_x), .y(s_y), .bin(brw_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         brw_q   <= 1'b0;
         xl_q    <= '0;
         yl_q    <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         brw_q   <= brw_d;
         xl_q    <= xl_d;
         yl_q    <= yl_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = accept                           ? RUN  :
                (run && last)                    ? DONE :
                (state_q == DONE && out_ready)   ? IDLE : state_q;
   end

   always_comb begin
      cnt_d  = accept ? '0 : run ? cnt_q + CW'(1) : cnt_q;
      brw_d  = accept ? bin : run ? s_bout : brw_q;
      xl_d   = accept ? x : xl_q;
      yl_d   = accept ? y : yl_q;
      diff_d = diff_q;
      if (run) diff_d[cnt_q*SLICE +: SLICE] = s_d;
      bout_d = (run && last) ? s_bout : bout_q;
      zero_d = (run && last) ? (diff_d == '0) : zero_q;
      ovf_d  = (run && last) ? ((xl_q[WIDTH-1] ^ yl_q[WIDTH-1]) & (diff_d[WIDTH-1] ^ xl_q[WIDTH-1])) : ovf_q;
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      d         = diff_q;
      bout      = bout_q;
      zero      = zero_q;
      ovf       = ovf_q;
   end
endmodule

// File: tb/tb_lab_iterative_borrow_sub.sv
// tb_lab_iterative_borrow_sub: directed and randomized checks of the iterative subtractor
// in the default 16/4 and a narrow 8/4 configuration against an arithmetic model.
module tb_lab_iterative_borrow_sub;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        a_in_valid = 1'b0, a_in_ready, a_bin = 1'b0, a_out_valid, a_out_ready = 1'b0;
   logic [15:0] a_x = '0, a_y = '0, a_d;
   logic        a_bout, a_zero, a_ovf;
   logic        b_in_valid = 1'b0, b_in_ready, b_bin = 1'b0, b_out_valid, b_out_ready = 1'b0;
   logic [7:0]  b_x = '0, b_y = '0, b_d;
   logic        b_bout, b_zero, b_ovf;

   int n_cmp = 0;
   int n_err = 0;

   lab_iterative_borrow_sub u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .x(a_x), .y(a_y), .bin(a_bin), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .d(a_d), .bout(a_bout), .zero(a_zero), .ovf(a_ovf)
   );

   lab_iterative_borrow_sub #(.WIDTH(8), .SLICE(4)) u_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .x(b_x), .y(b_y), .bin(b_bin), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .d(b_d), .bout(b_bout), .zero(b_zero), .ovf(b_ovf)
   );

   // plain integer arithmetic: unsigned result for d/bout, signed range for ovf
   function automatic void model(input int w, input logic [15:0] xa, input logic [15:0] ya,
                                 input logic c, output logic [15:0] dd, output logic bo,
                                 output logic z, output logic ov);
      longint m = longint'(1) << w;
      longint ux = longint'(xa), uy = longint'(ya);
      longint r = ux - uy - longint'(c);
      longint sx = (ux >= m / 2) ? ux - m : ux;
      longint sy = (uy >= m / 2) ? uy - m : uy;
      longint s = sx - sy - longint'(c);
      dd = 16'((r + m) % m);
      bo = (r < 0);
      z  = (dd == 0);
      ov = (s < -(m / 2)) || (s > m / 2 - 1);
   endfunction

   task automatic op_a(input logic [15:0] xv, input logic [15:0] yv, input logic c, output int lat);
      @(negedge clk);
      a_in_valid = 1'b1; a_x = xv; a_y = yv; a_bin = c;
      @(posedge clk); #1;
      a_in_valid = 1'b0; a_x = 16'($urandom); a_y = 16'($urandom); a_bin = 1'($urandom);
      lat = 0;
      while (!a_out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic consume_a();
      @(negedge clk); a_out_ready = 1'b1;
      @(posedge clk); #1; a_out_ready = 1'b0;
   endtask

   task automatic op_b(input logic [7:0] xv, input logic [7:0] yv, input logic c, output int lat);
      @(negedge clk);
      b_in_valid = 1'b1; b_x = xv; b_y = yv; b_bin = c;
      @(posedge clk); #1;
      b_in_valid = 1'b0; b_x = 8'($urandom); b_y = 8'($urandom); b_bin = 1'($urandom);
      lat = 0;
      while (!b_out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic consume_b();
      @(negedge clk); b_out_ready = 1'b1;
      @(posedge clk); #1; b_out_ready = 1'b0;
   endtask

   task automatic check_a(input string nm, input logic [15:0] xv, input logic [15:0] yv,
                          input logic c, input int lat);
      logic [15:0] ed; logic eb, ez, eo;
      model(16, xv, yv, c, ed, eb, ez, eo);
      n_cmp++;
      if (lat !== 4) begin n_err++; $display("FAIL %s latency: got %0d want 4", nm, lat); end
      n_cmp++;
      if ({a_d, a_bout, a_zero, a_ovf} !== {ed, eb, ez, eo})
         begin n_err++; $display("FAIL %s result: got d=%h b=%b z=%b o=%b want d=%h b=%b z=%b o=%b", nm, a_d, a_bout, a_zero, a_ovf, ed, eb, ez, eo); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      n_cmp++;
      if ({a_in_ready, a_out_valid, a_d, a_bout, a_zero, a_ovf} !== {1'b1, 1'b0, 16'h0, 3'b000})
         begin n_err++; $display("FAIL reset: got rdy=%b vld=%b d=%h b=%b z=%b o=%b want 1 0 0000 0 0 0", a_in_ready, a_out_valid, a_d, a_bout, a_zero, a_ovf); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_directed();
      int lat;
      logic [15:0] xs [3] = '{16'h1234, 16'h0005, 16'h8000};
      logic [15:0] ys [3] = '{16'h0235, 16'h000D, 16'h0001};
      logic        bs [3] = '{1'b0, 1'b1, 1'b0};
      logic [15:0] ds [3] = '{16'h0FFF, 16'hFFF7, 16'h7FFF};
      logic        bo [3] = '{1'b0, 1'b1, 1'b0};
      logic        ov [3] = '{1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         op_a(xs[i], ys[i], bs[i], lat);
         n_cmp++;
         if (lat !== 4) begin n_err++; $display("FAIL directed%0d latency: got %0d want 4", i, lat); end
         n_cmp++;
         if ({a_d, a_bout, a_zero, a_ovf} !== {ds[i], bo[i], 1'b0, ov[i]})
            begin n_err++; $display("FAIL directed%0d: got d=%h b=%b z=%b o=%b want d=%h b=%b z=0 o=%b", i, a_d, a_bout, a_zero, a_ovf, ds[i], bo[i], ov[i]); end
         consume_a();
      end
   endtask

   task automatic test_zero_backpressure();
      int lat;
      op_a(16'hABCD, 16'hABCD, 1'b0, lat);
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if ({a_out_valid, a_in_ready, a_d, a_zero, a_bout, a_ovf} !== {1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0})
            begin n_err++; $display("FAIL backpressure cyc%0d: got vld=%b rdy=%b d=%h z=%b want 1 0 0000 1", i, a_out_valid, a_in_ready, a_d, a_zero); end
         if (i < 3) begin @(posedge clk); #1; end
      end
      consume_a();
      n_cmp++;
      if ({a_in_ready, a_out_valid, a_d, a_zero} !== {1'b1, 1'b0, 16'h0, 1'b1})
         begin n_err++; $display("FAIL after handshake: got rdy=%b vld=%b d=%h z=%b want 1 0 0000 1", a_in_ready, a_out_valid, a_d, a_zero); end
   endtask

   task automatic test_reset_mid_run();
      int lat;
      op_a(16'hFFFF, 16'h0001, 1'b0, lat);
      consume_a();
      @(negedge clk); a_in_valid = 1'b1; a_x = 16'h0000; a_y = 16'h0001; a_bin = 1'b1;
      @(posedge clk); #1; a_in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({a_in_ready, a_out_valid, a_d, a_bout, a_zero, a_ovf} !== {1'b1, 1'b0, 16'h0, 3'b000})
         begin n_err++; $display("FAIL mid-run reset: got rdy=%b vld=%b d=%h b=%b z=%b o=%b want 1 0 0000 0 0 0", a_in_ready, a_out_valid, a_d, a_bout, a_zero, a_ovf); end
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      op_a(16'h4000, 16'hC000, 1'b1, lat);
      check_a("post-reset", 16'h4000, 16'hC000, 1'b1, lat);
      consume_a();
   endtask

   task automatic test_narrow();
      int lat;
      op_b(8'h0C, 8'h05, 1'b1, lat);
      n_cmp++;
      if (lat !== 2) begin n_err++; $display("FAIL narrow latency: got %0d want 2", lat); end
      n_cmp++;
      if ({b_d, b_bout} !== {8'h06, 1'b0}) begin n_err++; $display("FAIL narrow0: got d=%h b=%b want d=06 b=0", b_d, b_bout); end
      consume_b();
      op_b(8'h06, 8'h0D, 1'b1, lat);
      n_cmp++;
      if ({b_d, b_bout} !== {8'hF8, 1'b1}) begin n_err++; $display("FAIL narrow1: got d=%h b=%b want d=f8 b=1", b_d, b_bout); end
      consume_b();
      for (int i = 0; i < 12; i++) begin
         logic [7:0] xv, yv; logic c; logic [15:0] ed; logic eb, ez, eo;
         xv = 8'($urandom); yv = (i % 4 == 0) ? xv : 8'($urandom); c = (i % 4 == 0) ? 1'b0 : 1'($urandom);
         model(8, {8'h0, xv}, {8'h0, yv}, c, ed, eb, ez, eo);
         op_b(xv, yv, c, lat);
         n_cmp++;
         if ({lat[7:0], b_d, b_bout, b_zero, b_ovf} !== {8'd2, ed[7:0], eb, ez, eo})
            begin n_err++; $display("FAIL narrow rand%0d %h-%h-%b: got lat=%0d d=%h b=%b z=%b o=%b want lat=2 d=%h b=%b z=%b o=%b", i, xv, yv, c, lat, b_d, b_bout, b_zero, b_ovf, ed[7:0], eb, ez, eo); end
         consume_b();
      end
   endtask

   task automatic test_random();
      int lat;
      for (int i = 0; i < 40; i++) begin
         logic [15:0] xv, yv; logic c;
         xv = 16'($urandom);
         yv = (i % 8 == 0) ? xv : (i % 8 == 1) ? xv ^ 16'h8000 : 16'($urandom);
         c = (i % 8 == 0) ? 1'b0 : 1'($urandom);
         op_a(xv, yv, c, lat);
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
         end
         check_a($sformatf("rand%0d", i), xv, yv, c, lat);
         consume_a();
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [15:0] xv, yv;
      for (int i = 0; i < 6; i++) begin
         xv = 16'($urandom); yv = 16'($urandom);
         op_a(xv, yv, 1'b1, lat);
         check_a($sformatf("b2b%0d", i), xv, yv, 1'b1, lat);
         @(negedge clk); a_out_ready = 1'b1;
         n_cmp++;
         if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL b2b%0d in_ready in DONE: got %b want 0", i, a_in_ready); end
         @(posedge clk); #1; a_out_ready = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_zero_backpressure();
      test_reset_mid_run();
      test_random();
      test_back_to_back();
      test_narrow();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
